ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 10, RAM address width.
REQ-002 Parameter: WORD_W, default 8, RAM data width.
REQ-003 Parameter: MEM_DEPTH, default 1024, number of RAM words.
REQ-004 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-005 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port: a_req / b_req  input  1  requester A/B command valid, held until matching ack.
REQ-007 Port: a_we / b_we  input  1  1 = write, 0 = read.
REQ-008 Port: a_addr / b_addr  input  ADDR_W  word address.
REQ-009 Port: a_wdata / b_wdata  input  WORD_W  write data.
REQ-010 Port: a_ack / b_ack  output  1  one-cycle completion pulse.
REQ-011 Port: a_rdata / b_rdata  output  WORD_W  read data, valid in the ack cycle and held until that requester's next read completes.
REQ-012 Port: mem_addr  output  ADDR_W  RAM address.
REQ-013 Port: mem_wdata  output  WORD_W  RAM write data.
REQ-014 Port: mem_rdata  input  WORD_W  RAM read data, combinational from mem_addr.
REQ-015 Port: mem_wr / mem_cs  output  1  RAM write enable / chip select.
REQ-016 Port: busy  output  1  high while memory clear sweep is in progress.

Function
REQ-017 The FSM SHALL have states CLEAR, IDLE, ACCESS, RESP.
REQ-018 In IDLE with any req high, the block SHALL pick a winner, latch its we/addr/wdata, and move to ACCESS at the next edge.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests the pointer side wins; after every grant the pointer flips to the other requester.
REQ-020 In ACCESS, mem_cs SHALL be 1, mem_addr/mem_wdata SHALL carry latched values, mem_wr SHALL equal latched we; mem_rdata SHALL be captured into the winner's rdata register at the ACCESS-ending edge (reads only).
REQ-021 In RESP, exactly the winner's ack SHALL be 1 for one cycle; mem_cs and mem_wr SHALL be 0; next state IDLE.
REQ-022 Latency: req sampled high in IDLE at cycle T -> ack in cycle T+2; one transaction per 3 cycles; a_ack and b_ack SHALL never be high together.
REQ-023 A req still high in the IDLE cycle after its ack SHALL be treated as a new command.
REQ-024 Outside ACCESS and CLEAR, mem_cs and mem_wr SHALL be 0.
REQ-025 Addresses SHALL be used unmodified; MEM_DEPTH-1 is a valid address, no wrap or range check.

Reset
REQ-026 With rst_n low at a clock edge: a_ack, b_ack, a_rdata, b_rdata, mem_addr, mem_wdata, mem_wr, mem_cs SHALL be 0; round-robin pointer SHALL be A.
REQ-027 Reset mid-transaction SHALL abort it with no ack; the requester re-presents its command afterwards.
REQ-028 Post-reset state SHALL be CLEAR when RAM_CLEAR_EN is defined, else IDLE.

Configuration
REQ-029 Macro RAM_CLEAR_EN defined: after reset the FSM SHALL write 0 to addresses 0..MEM_DEPTH-1, one per cycle (mem_cs=mem_wr=1), then enter IDLE; busy SHALL be 1 from reset through the last clear write, for exactly MEM_DEPTH cycles after reset release; requests SHALL be ignored (not acked) during CLEAR.
REQ-030 Macro RAM_CLEAR_EN undefined: no CLEAR state or sweep counter SHALL exist; busy SHALL be constant 0.

Structure
REQ-031 Package ram_ctrl_pkg SHALL hold default ADDR_W/WORD_W/MEM_DEPTH constants and the FSM state typedef.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs: two requests, advance strobe; outputs: one-hot grant, pointer).

Verification
REQ-033 A write addr 5 data 0x3C, then A read addr 5 -> each ack at T+2, a_rdata = 0x3C.
REQ-034 a_req and b_req both rise same cycle after reset (idle) -> A acked first, B acked 3 cycles later, acks never coincident.
REQ-035 b_req held high continuously, a_req held high -> acks alternate A, B, A, B.
REQ-036 A write addr 0x3FF data 0xFF, B read addr 0x3FF -> b_rdata = 0xFF, a_rdata unchanged.
REQ-037 rst_n low for one cycle during ACCESS -> no ack for aborted command, outputs per REQ-026 next cycle, re-presented command completes normally.
REQ-038 RAM_CLEAR_EN defined: busy high exactly 1024 cycles after reset release, a_req during sweep acked only after busy falls, read addr 1023 -> 0x00.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared defaults and FSM state type for ram_arbiter
// RAM_CLEAR_EN adds the CLEAR state used by the power-on memory sweep.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_WORD_W    = 8;
  localparam int DEF_MEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
`ifdef RAM_CLEAR_EN
    , ST_CLEAR  = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter
// grant[0] = A, grant[1] = B; ptr 0 favours A on a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = 2'b00;
    if (req_a && (!req_b || !ptr)) begin
      grant = 2'b01;
    end else if (req_b) begin
      grant = 2'b10;
    end
  end

  // After a grant the pointer favours the side that just lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester single-port RAM arbiter, 3-cycle transactions
// RAM_CLEAR_EN enables a zero-fill sweep of the whole RAM after reset.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WORD_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [WORD_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WORD_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [WORD_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic              mem_cs,
  output logic              busy
);

  state_t state, state_nxt;

  logic [1:0]        grant;
  logic              rr_ptr;
  logic              advance;
  logic              lat_sel;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_wdata;

  assign advance = (state == ST_IDLE) && (grant != 2'b00);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (a_req),
    .req_b   (b_req),
    .advance (advance),
    .grant   (grant),
    .ptr     (rr_ptr)
  );

`ifdef RAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef RAM_CLEAR_EN
      state <= ST_CLEAR;
`else
      state <= ST_IDLE;
`endif
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (advance) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
`ifdef RAM_CLEAR_EN
      ST_CLEAR:  if (clr_cnt == ADDR_W'(MEM_DEPTH - 1)) state_nxt = ST_IDLE;
`endif
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // On a tie the pointer names the winner; otherwise the lone requester wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_sel   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (advance) begin
      lat_sel   <= (a_req && b_req) ? rr_ptr : grant[1];
      lat_we    <= grant[1] ? b_we    : a_we;
      lat_addr  <= grant[1] ? b_addr  : a_addr;
      lat_wdata <= grant[1] ? b_wdata : a_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if ((state == ST_ACCESS) && !lat_we) begin
      if (lat_sel) begin
        b_rdata <= mem_rdata;
      end else begin
        a_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_cs    = (state == ST_ACCESS);
    mem_wr    = (state == ST_ACCESS) && lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    a_ack     = (state == ST_RESP) && !lat_sel;
    b_ack     = (state == ST_RESP) && lat_sel;
    busy      = 1'b0;
`ifdef RAM_CLEAR_EN
    if (state == ST_CLEAR) begin
      mem_cs    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = '0;
      busy      = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter
// Honours RAM_CLEAR_EN when compiled with it.
module tb_ram_arbiter;

  localparam int AW    = 10;
  localparam int WW    = 8;
  localparam int DEPTH = 1024;
`ifdef RAM_CLEAR_EN
  localparam int CLR_CYC = DEPTH;
  localparam bit CLR_ON  = 1'b1;
`else
  localparam int CLR_CYC = 0;
  localparam bit CLR_ON  = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          a_req, a_we, a_ack;
  logic [AW-1:0] a_addr;
  logic [WW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_ack;
  logic [AW-1:0] b_addr;
  logic [WW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata, mem_rdata;
  logic          mem_wr, mem_cs, busy;

  ram_arbiter #(.ADDR_W(AW), .WORD_W(WW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_cs(mem_cs), .busy(busy)
  );

  logic [WW-1:0] ram [0:DEPTH-1];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_cs && mem_wr) ram[mem_addr] <= mem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            rd;
    logic [WW-1:0] data;
    int            at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pops that side's expectation.
  always @(negedge clk) begin
    exp_t e;
    if (a_ack || b_ack) chk("ack_exclusive", {31'd0, a_ack & b_ack}, 32'd0);
    if (a_ack) begin
      chk("a_resp_cs_wr", {30'd0, mem_cs, mem_wr}, 32'd0);
      if (qa.size() == 0) begin
        chk("a_unexpected_ack", qa.size(), 32'd1);
      end else begin
        e = qa.pop_front();
        chk("a_ack_cycle", cyc, e.at);
        if (e.rd) chk("a_rdata", {24'd0, a_rdata}, {24'd0, e.data});
      end
    end
    if (b_ack) begin
      chk("b_resp_cs_wr", {30'd0, mem_cs, mem_wr}, 32'd0);
      if (qb.size() == 0) begin
        chk("b_unexpected_ack", qb.size(), 32'd1);
      end else begin
        e = qb.pop_front();
        chk("b_ack_cycle", cyc, e.at);
        if (e.rd) chk("b_rdata", {24'd0, b_rdata}, {24'd0, e.data});
      end
    end
  end

  task automatic wait_ack(input bit side, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (side ? b_ack : a_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk(side ? "b_ack_seen" : "a_ack_seen", {31'd0, got}, 32'd1);
    if (side) b_req = 1'b0;
    else      a_req = 1'b0;
  endtask

  task automatic issue(input bit side, input bit we, input logic [AW-1:0] addr,
                       input logic [WW-1:0] wd, input logic [WW-1:0] exp_rd, input int extra);
    exp_t e;
    @(negedge clk);
    e.rd   = !we;
    e.data = exp_rd;
    e.at   = cyc + 2 + extra;
    if (side) begin
      b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
      qb.push_back(e);
    end else begin
      a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
      qa.push_back(e);
    end
    wait_ack(side, 12);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_a_ack",     {31'd0, a_ack}, 32'd0);
    chk("rst_b_ack",     {31'd0, b_ack}, 32'd0);
    chk("rst_a_rdata",   {24'd0, a_rdata}, 32'd0);
    chk("rst_b_rdata",   {24'd0, b_rdata}, 32'd0);
    chk("rst_mem_addr",  {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_mem_wr",    {31'd0, mem_wr}, {31'd0, CLR_ON});
    chk("rst_mem_cs",    {31'd0, mem_cs}, {31'd0, CLR_ON});
  endtask

  initial begin
    exp_t e;
    int   k;
    int   nb;
    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    chk("rst_busy", {31'd0, busy}, {31'd0, CLR_ON});
    rst_n = 1'b1;

`ifdef RAM_CLEAR_EN
    a_we = 1'b0; a_addr = 10'h3FF; a_req = 1'b1;
    e.rd = 1'b1; e.data = 8'h00; e.at = cyc + DEPTH + 2;
    qa.push_back(e);
    nb = 0;
    fork
      begin
        for (int i = 0; i < DEPTH + 8; i++) begin
          if (busy) nb++;
          @(negedge clk);
        end
      end
      wait_ack(1'b0, DEPTH + 20);
    join
    chk("busy_cycles", nb, DEPTH);
`else
    nb = 0;
    chk("busy_const_zero", {31'd0, busy}, 32'd0);
`endif

    // Simultaneous first requests: A wins, B three cycles later.
    fork
      issue(1'b0, 1'b1, 10'd5,   8'h3C, 8'h00, 0);
      issue(1'b1, 1'b1, 10'h3FF, 8'h81, 8'h00, 3);
    join

    issue(1'b0, 1'b1, 10'd5, 8'h3C, 8'h00, 0);
    issue(1'b0, 1'b0, 10'd5, 8'h00, 8'h3C, 0);

    issue(1'b0, 1'b1, 10'h3FF, 8'hFF, 8'h00, 0);
    issue(1'b1, 1'b0, 10'h3FF, 8'h00, 8'hFF, 0);
    chk("a_rdata_held", {24'd0, a_rdata}, 32'h3C);

    // Both held high: A, B, A, B at 3-cycle spacing.
    @(negedge clk);
    k = cyc;
    a_we = 1'b0; a_addr = 10'd5;   a_req = 1'b1;
    b_we = 1'b0; b_addr = 10'h3FF; b_req = 1'b1;
    e.rd = 1'b1; e.data = 8'h3C;
    e.at = k + 2;  qa.push_back(e);
    e.at = k + 8;  qa.push_back(e);
    e.data = 8'hFF;
    e.at = k + 5;  qb.push_back(e);
    e.at = k + 11; qb.push_back(e);
    nb = 0;
    for (int i = 0; i < 20 && nb < 2; i++) begin
      @(negedge clk);
      if (b_ack) nb++;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    chk("alt_b_acks", nb, 32'd2);

    // Reset pulse during ACCESS aborts the read; re-presented command completes.
    @(negedge clk);
    a_we = 1'b0; a_addr = 10'd5; a_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    e.rd = 1'b1; e.data = CLR_ON ? 8'h00 : 8'h3C; e.at = cyc + 2 + CLR_CYC;
    qa.push_back(e);
    wait_ack(1'b0, CLR_CYC + 12);

    issue(1'b1, 1'b1, 10'd0, 8'h5A, 8'h00, 0);
    issue(1'b1, 1'b0, 10'd0, 8'h00, 8'h5A, 0);

    repeat (6) @(negedge clk);
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
